smi_axi_input_buffer: RTL and testbench

- AXI-stream-style slave to SMI/SELF valid/stop input buffer. It is the receive-side counterpart of the SMI AXI output buffer.
- Accepts beats from an AXI master on `axiValid`/`axiReady` and presents them to the downstream SELF consumer on `dataOutValid`/`dataOutStop`.
- Storage is a parameterised-depth circular FIFO.
- `axiReady` is driven directly from a flop, so there is no combinational path from `axiValid` or `dataOutStop` to `axiReady`.
- Sits at every AXI-to-SMI ingress point of the action logic.

---
 rtl/smi_axi_input_buffer_pkg.sv | 18 +
 rtl/smi_axi_input_buffer_if.sv | 11 +
 rtl/smi_axi_input_buffer_store.sv | 25 ++
 rtl/smi_axi_input_buffer.sv | 54 +++++
 tb/tb_smi_axi_input_buffer.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/smi_axi_input_buffer_pkg.sv
// smi_axi_pkg: shared width helpers and beat-handshake constants for the SMI AXI buffers.
package smi_axi_pkg;
    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction
    function automatic int ptr_w(input int depth);
        return clog2(depth);
    endfunction
    function automatic int cnt_w(input int depth);
        return clog2(depth) + 1;
    endfunction
    localparam logic READY_IN_RESET = 1'b0;
    localparam logic VALID_IN_RESET = 1'b0;
    localparam int BEATS_PER_CYCLE = 1;
endpackage

// File: rtl/smi_axi_input_buffer_if.sv
// smi_axi_input_buffer_if: AXI-side beat handshake plus SELF valid/stop output bundle.
interface smi_axi_input_buffer_if #(parameter int DataWidth = 16);
    logic                 axiValid;
    logic [DataWidth-1:0] axiDataIn;
    logic                 axiReady;
    logic                 dataOutValid;
    logic [DataWidth-1:0] dataOut;
    logic                 dataOutStop;
    modport slave (input axiValid, axiDataIn, dataOutStop, output axiReady, dataOutValid, dataOut);
    modport master (output axiValid, axiDataIn, dataOutStop, input axiReady, dataOutValid, dataOut);
endinterface

// File: rtl/smi_axi_input_buffer_store.sv
// smi_fifo_store: register-array FIFO storage, synchronous write and asynchronous head read.
module smi_fifo_store
    import smi_axi_pkg::*;
#(
    parameter int DataWidth = 16,
    parameter int Depth = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we,
    input  logic [ptr_w(Depth)-1:0]   waddr,
    input  logic [DataWidth-1:0]      wdata,
    input  logic [ptr_w(Depth)-1:0]   raddr,
    output logic [DataWidth-1:0]      rdata
);
    logic [DataWidth-1:0] mem [Depth];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/smi_axi_input_buffer.sv
// smi_axi_input_buffer: AXI-stream slave to SELF valid/stop circular FIFO buffer.
// Optional level/full outputs enabled by defining SMI_AXI_INPUT_LEVEL_EN.
module smi_axi_input_buffer
    import smi_axi_pkg::*;
#(
    parameter int DataWidth = 16,
    parameter int FifoDepth = 4
) (
    input logic                     clk,
    input logic                     rst_n,
`ifdef SMI_AXI_INPUT_LEVEL_EN
    output logic [cnt_w(FifoDepth)-1:0] fifoLevel,
    output logic                        fifoFull,
`endif
    smi_axi_input_buffer_if.slave   bus
);
    localparam int PW = ptr_w(FifoDepth);
    localparam int CW = cnt_w(FifoDepth);
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          ready, push, pop;
    assign push = bus.axiValid & ready;
    assign pop = bus.dataOutValid & ~bus.dataOutStop;
    assign cnt_nxt = cnt + CW'(push) - CW'(pop);
    assign bus.axiReady = ready;
    assign bus.dataOutValid = (cnt != '0);
    // ready is registered from the next count so the AXI side never sees a combinational path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt <= '0;
            ready <= READY_IN_RESET;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt_nxt;
            ready <= (cnt_nxt < CW'(FifoDepth));
        end
    end
    smi_fifo_store #(.DataWidth(DataWidth), .Depth(FifoDepth)) u_store (
        .clk(clk),
        .rst_n(rst_n),
        .we(push),
        .waddr(wr_ptr),
        .wdata(bus.axiDataIn),
        .raddr(rd_ptr),
        .rdata(bus.dataOut)
    );
`ifdef SMI_AXI_INPUT_LEVEL_EN
    assign fifoLevel = cnt;
    assign fifoFull = (cnt == CW'(FifoDepth));
`endif
endmodule

// File: tb/tb_smi_axi_input_buffer.sv
// tb_smi_axi_input_buffer: directed and queue-scoreboarded checks of smi_axi_input_buffer.
module tb_smi_axi_input_buffer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [15:0] q[$];
    smi_axi_input_buffer_if #(.DataWidth(16)) bus ();
`ifdef SMI_AXI_INPUT_LEVEL_EN
    logic [2:0] fifoLevel;
    logic       fifoFull;
`endif
    smi_axi_input_buffer #(.DataWidth(16), .FifoDepth(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef SMI_AXI_INPUT_LEVEL_EN
        .fifoLevel(fifoLevel),
        .fifoFull(fifoFull),
`endif
        .bus(bus)
    );
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks outputs against the queue model, then advances one clock; returns whether a push fired.
    task automatic cycle(output bit pushed);
        bit pop;
        check("valid_vs_model", 32'(bus.dataOutValid), 32'(q.size() != 0));
        check("ready_vs_model", 32'(bus.axiReady), 32'(q.size() < 4));
        if (q.size() != 0) check("head_vs_model", 32'(bus.dataOut), 32'(q[0]));
`ifdef SMI_AXI_INPUT_LEVEL_EN
        check("level", 32'(fifoLevel), 32'(q.size()));
        check("full", 32'(fifoFull), 32'(q.size() == 4));
`endif
        pushed = bus.axiValid && bus.axiReady;
        pop = bus.dataOutValid && !bus.dataOutStop;
        if (pop && q.size() != 0) void'(q.pop_front());
        if (pushed) q.push_back(bus.axiDataIn);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bit p;
        int npush, ncyc, nstream;
        logic [15:0] dout_seq[$];
        bus.axiValid = 1'b0;
        bus.axiDataIn = '0;
        bus.dataOutStop = 1'b0;
        // reset held for three cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(bus.axiReady), 0);
        check("rst_valid", 32'(bus.dataOutValid), 0);
        check("rst_data", 32'(bus.dataOut), 0);
        rst_n = 1'b1;
        #1 check("ready_before_first_edge", 32'(bus.axiReady), 0);
        @(negedge clk);
        check("ready_after_first_edge", 32'(bus.axiReady), 1);
        // single beat
        bus.axiValid = 1'b1;
        bus.axiDataIn = 16'h1234;
        cycle(p);
        bus.axiValid = 1'b0;
        check("single_valid", 32'(bus.dataOutValid), 1);
        check("single_data", 32'(bus.dataOut), 32'h1234);
        cycle(p);
        check("single_drained", 32'(bus.dataOutValid), 0);
        // fill with stop held
        bus.dataOutStop = 1'b1;
        bus.axiValid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.axiDataIn = 16'(i);
            cycle(p);
        end
        check("full_ready_low", 32'(bus.axiReady), 0);
        check("full_head", 32'(bus.dataOut), 32'h0001);
        bus.axiDataIn = 16'h0005;
        for (int i = 0; i < 3; i++) cycle(p);
        check("full_fifth_blocked", 32'(q.size()), 4);
        check("full_head_stable", 32'(bus.dataOut), 32'h0001);
        // drain, 0x0005 still offered until accepted
        bus.dataOutStop = 1'b0;
        ncyc = 0;
        while ((bus.dataOutValid || bus.axiValid) && ncyc < 20) begin
            if (bus.dataOutValid) dout_seq.push_back(bus.dataOut);
            cycle(p);
            if (ncyc == 0) check("ready_after_first_pop", 32'(bus.axiReady), 1);
            if (p) bus.axiValid = 1'b0;
            ncyc++;
        end
        check("drain_count", 32'(dout_seq.size()), 5);
        for (int i = 0; i < dout_seq.size(); i++) check("drain_order", 32'(dout_seq[i]), 32'(i + 1));
        // random streaming of 1000 incrementing beats
        npush = 0;
        ncyc = 0;
        nstream = 0;
        bus.axiDataIn = 16'h0100;
        while ((npush < 1000 || q.size() != 0) && ncyc < 20000) begin
            bus.axiValid = (npush < 1000) && ($urandom_range(0, 3) != 0);
            bus.dataOutStop = ($urandom_range(0, 2) == 0);
            cycle(p);
            if (p) begin
                npush++;
                bus.axiDataIn = bus.axiDataIn + 16'd1;
            end
            ncyc++;
        end
        check("stream_all_pushed", 32'(npush), 1000);
        check("stream_drained", 32'(bus.dataOutValid), 0);
        // full throughput when both sides always active
        bus.axiValid = 1'b1;
        bus.dataOutStop = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle(p);
            if (p) nstream++;
            bus.axiDataIn = bus.axiDataIn + 16'(p);
        end
        check("throughput", 32'(nstream), 20);
        bus.axiValid = 1'b0;
        for (int i = 0; i < 3; i++) cycle(p);
        // asynchronous reset with three entries held
        bus.dataOutStop = 1'b1;
        bus.axiValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.axiDataIn = 16'hA000 + 16'(i);
            cycle(p);
        end
        bus.axiValid = 1'b0;
        check("pre_rst_held", 32'(bus.dataOutValid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_ready", 32'(bus.axiReady), 0);
        check("async_rst_valid", 32'(bus.dataOutValid), 0);
        check("async_rst_data", 32'(bus.dataOut), 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(bus.axiReady), 1);
        check("post_rst_empty", 32'(bus.dataOutValid), 0);
        bus.dataOutStop = 1'b0;
        bus.axiValid = 1'b1;
        bus.axiDataIn = 16'hBEEF;
        cycle(p);
        bus.axiValid = 1'b0;
        check("post_rst_first_out", 32'(bus.dataOut), 32'hBEEF);
        cycle(p);
        check("post_rst_drained", 32'(bus.dataOutValid), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
